// File: rtl/div_pkg.sv
// Shared definitions for the iterative radix-2 divider: op bit positions,
// FSM state encoding and the iteration counter width.
package div_pkg;

  localparam int DIV_SIGNED = 0;
  localparam int DIV_WORD   = 1;
  localparam int DIV_REM    = 2;

  // Sized for the widest legal datapath so one counter type serves both XLENs
  localparam int XLEN_MAX = 64;
  localparam int CNT_W    = $clog2(XLEN_MAX);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_prep.sv
// Combinational operand preparation: word truncation, magnitudes, result
// signs and the divide-by-zero / signed-overflow flags, registered on accept.
module div_prep #(
  parameter int XLEN = 64
) (
  input  logic            is_signed,
  input  logic            is_word,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] dividend,
  output logic [XLEN-1:0] mag1,
  output logic [XLEN-1:0] mag2,
  output logic            q_neg,
  output logic            r_neg,
  output logic            div_zero,
  output logic            overflow
);

  logic [XLEN-1:0] ext1, ext2, zext1, zext2, abs1;
  logic            sign1, sign2;

  always_comb begin
    ext1  = is_word ? XLEN'($signed(op1[31:0])) : op1;
    ext2  = is_word ? XLEN'($signed(op2[31:0])) : op2;
    zext1 = is_word ? XLEN'(op1[31:0]) : op1;
    zext2 = is_word ? XLEN'(op2[31:0]) : op2;
    sign1 = is_signed & ext1[XLEN-1];
    sign2 = is_signed & ext2[XLEN-1];
    abs1  = sign1 ? -ext1 : zext1;
    mag2  = sign2 ? -ext2 : zext2;
    // Word dividends sit at the top so the MSB is shifted out after only 32 steps
    mag1  = is_word ? (abs1 << (XLEN - 32)) : abs1;
    dividend = ext1;
    q_neg    = sign1 ^ sign2;
    r_neg    = sign1;
    div_zero = (zext2 == '0);
    overflow = is_signed & (&ext2) &
               (is_word ? (op1[31:0] == 32'h8000_0000)
                        : (op1 == {1'b1, {(XLEN-1){1'b0}}}));
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider with valid/ready handshakes and flush; covers
// DIV/DIVU/REM/REMU and the W forms with exact zero-divisor/overflow results.
module div_iter
  import div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  input  logic            flush
);

  div_state_t      state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [2*XLEN-1:0] sr, sr_next;
  logic [XLEN-1:0] divisor;
  logic            op_rem, op_word, q_neg_r, r_neg_r;

  logic            p_word, p_q_neg, p_r_neg, p_zero, p_ovf;
  logic [XLEN-1:0] p_dividend, p_mag1, p_mag2;
  logic            accept, special;
  logic [XLEN-1:0] special_result, fix_result, q_fix, r_fix, sel;
  logic [XLEN:0]   trial, diff;

  assign p_word = (XLEN == 64) & op[DIV_WORD];

  div_prep #(.XLEN(XLEN)) u_prep (
    .is_signed (op[DIV_SIGNED]),
    .is_word   (p_word),
    .op1       (op1),
    .op2       (op2),
    .dividend  (p_dividend),
    .mag1      (p_mag1),
    .mag2      (p_mag2),
    .q_neg     (p_q_neg),
    .r_neg     (p_r_neg),
    .div_zero  (p_zero),
    .overflow  (p_ovf)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid & in_ready & ~flush;
  assign special   = p_zero | p_ovf;

  always_comb begin
    if (p_zero) special_result = op[DIV_REM] ? p_dividend : '1;
    else        special_result = op[DIV_REM] ? '0 : p_dividend;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    trial = {sr[2*XLEN-1:XLEN], sr[XLEN-1]};
    diff  = trial - {1'b0, divisor};
    if (!diff[XLEN]) sr_next = {diff[XLEN-1:0], sr[XLEN-2:0], 1'b1};
    else             sr_next = {trial[XLEN-1:0], sr[XLEN-2:0], 1'b0};
  end

  always_comb begin
    q_fix = q_neg_r ? -sr[XLEN-1:0] : sr[XLEN-1:0];
    r_fix = r_neg_r ? -sr[2*XLEN-1:XLEN] : sr[2*XLEN-1:XLEN];
    sel   = op_rem ? r_fix : q_fix;
    fix_result = op_word ? XLEN'($signed(sel[31:0])) : sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = special ? DONE : CALC;
      CALC:    if (cnt == '0) next_state = FIX;
      FIX:     next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sr         <= '0;
      divisor    <= '0;
      op_rem     <= 1'b0;
      op_word    <= 1'b0;
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
      out_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_rem  <= op[DIV_REM];
            op_word <= p_word;
            q_neg_r <= p_q_neg;
            r_neg_r <= p_r_neg;
            divisor <= p_mag2;
            sr      <= {{XLEN{1'b0}}, p_mag1};
            cnt     <= p_word ? CNT_W'(31) : CNT_W'(XLEN - 1);
            if (special) out_result <= special_result;
          end
        end
        CALC: begin
          sr  <= sr_next;
          cnt <= cnt - CNT_W'(1);
        end
        FIX:     if (!flush) out_result <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter (XLEN=64): directed vector table, corner
// sequences (back-pressure, flush, async reset) and randomized ops vs a model.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [2:0]  op;
  logic [63:0] op1, op2, out_result;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  div_iter #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .op1        (op1),
    .op2        (op2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .flush      (flush)
  );

  initial forever #5 clk = ~clk;

  // Architectural RISC-V divide semantics, computed with plain arithmetic
  function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    a32 = a[31:0];
    b32 = b[31:0];
    if (o[1]) begin
      if (b32 == 32'd0) r32 = o[2] ? a32 : 32'hFFFF_FFFF;
      else if (o[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = o[2] ? 32'd0 : a32;
      else if (o[0]) r32 = o[2] ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
      else r32 = o[2] ? a32 % b32 : a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    if (b == 64'd0) r64 = o[2] ? a : '1;
    else if (o[0] && a == 64'h8000_0000_0000_0000 && b == '1) r64 = o[2] ? 64'd0 : a;
    else if (o[0]) r64 = o[2] ? 64'($signed(a) % $signed(b)) : 64'($signed(a) / $signed(b));
    else r64 = o[2] ? a % b : a / b;
    return r64;
  endfunction

  function automatic int model_latency(input logic [2:0] o, input logic [63:0] a,
                                       input logic [63:0] b);
    bit spec;
    if (o[1]) spec = (b[31:0] == 0) || (o[0] && a[31:0] == 32'h8000_0000 && b[31:0] == '1);
    else      spec = (b == 0) || (o[0] && a == 64'h8000_0000_0000_0000 && b == '1);
    if (spec) return 1;
    return o[1] ? 34 : 66;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%016h expected=0x%016h", name, actual, expected);
    end
  endtask

  // Issue one op, count edges to out_valid (accept edge = 1), hold the result
  // for 'hold' cycles, then take it.
  task automatic applyStimulus(input string name, input logic [2:0] o, input logic [63:0] a,
                               input logic [63:0] b, input int hold,
                               output logic [63:0] res, output int edges);
    @(negedge clk);
    checkOutput({name, "_in_ready"}, 64'(in_ready), 64'd1);
    op = o; op1 = a; op2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op  = 3'($urandom);
    op1 = {$urandom, $urandom};
    op2 = {$urandom, $urandom};
    edges = 1;
    while (!out_valid && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
    res = out_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({name, "_hold_valid"}, 64'(out_valid), 64'd1);
      checkOutput({name, "_hold_result"}, out_result, res);
      checkOutput({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({name, "_taken_in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({name, "_taken_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] res, a, b;
    logic [2:0]  o;
    int          edges;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    op = '0; op1 = '0; op2 = '0;

    vecs.push_back('{"div_m7_2",      3'b001, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66});
    vecs.push_back('{"rem_m7_2",      3'b101, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66});
    vecs.push_back('{"divu_by0",      3'b000, '1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    vecs.push_back('{"remu_by0",      3'b100, '1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1});
    vecs.push_back('{"div_ovf",       3'b001, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1});
    vecs.push_back('{"rem_ovf",       3'b101, 64'h8000_0000_0000_0000, '1, 64'd0, 1});
    vecs.push_back('{"divuw_1",       3'b010, 64'h1_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34});
    vecs.push_back('{"divw_ovf",      3'b011, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1});
    vecs.push_back('{"divu_100_7",    3'b000, 64'd100, 64'd7, 64'd14, 66});
    vecs.push_back('{"remuw_17_5",    3'b110, 64'h1_0000_0011, 64'd5, 64'd2, 34});
    vecs.push_back('{"remw_m7_2",     3'b111, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34});
    vecs.push_back('{"remw_by0",      3'b111, 64'h0000_0000_8000_0000, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0000, 1});

    #12;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_result", out_result, 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, 0, res, edges);
      checkOutput({vecs[i].name, "_result"}, res, vecs[i].exp);
      checkOutput({vecs[i].name, "_latency"}, 64'(edges), 64'(vecs[i].lat));
    end

    applyStimulus("backpressure", 3'b001, 64'd1000, 64'd7, 10, res, edges);
    checkOutput("backpressure_result", res, 64'd142);

    // Flush at CALC cycle 20, new op on the following cycle
    @(negedge clk);
    op = 3'b001; op1 = 64'd1000; op2 = 64'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checkOutput("flush_calc_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_calc_in_ready", 64'(in_ready), 64'd1);
    applyStimulus("after_flush", 3'b000, 64'd77, 64'd10, 0, res, edges);
    checkOutput("after_flush_result", res, 64'd7);
    checkOutput("after_flush_latency", 64'(edges), 64'd66);

    // Flush together with in_valid in IDLE must not accept
    @(negedge clk);
    op = 3'b000; op1 = 64'd5; op2 = 64'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checkOutput("flush_idle_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(posedge clk); #1;
    checkOutput("flush_idle_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    op = 3'b000; op1 = 64'd500; op2 = 64'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1; #1;
    checkOutput("rst_calc_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_calc_valid", 64'(out_valid), 64'd0);
    @(negedge clk); rst = 1'b0;

    // Asynchronous reset while a result waits in DONE
    @(negedge clk);
    op = 3'b000; op1 = 64'd5; op2 = 64'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("rst_done_pre_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1; #1;
    checkOutput("rst_done_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_done_result", out_result, 64'd0);
    @(negedge clk); rst = 1'b0;

    for (int n = 0; n < 40; n++) begin
      o = 3'($urandom);
      a = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0:       b = {$urandom, $urandom};
        1:       b = 64'($urandom_range(1, 1000));
        2:       b = {32'($urandom), 32'd0};
        3:       begin a = o[1] ? {32'($urandom), 32'h8000_0000} : 64'h8000_0000_0000_0000; b = '1; end
        default: b = -64'($urandom_range(1, 50));
      endcase
      applyStimulus($sformatf("rand%0d", n), o, a, b, $urandom_range(0, 2), res, edges);
      checkOutput($sformatf("rand%0d_result", n), res, model(o, a, b));
      checkOutput($sformatf("rand%0d_latency", n), 64'(edges), 64'(model_latency(o, a, b)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Multi-cycle, parametrised radix-2 integer divider for the NPC execute stage, replacing the single-cycle combinational divider on the long-latency path. It covers the RISC-V M-extension divide and remainder ops (DIV/DIVU/REM/REMU and the 32-bit W forms) with architecturally exact divide-by-zero and overflow results. A valid/ready handshake connects it to the EXU, and a flush input kills an in-flight op on redirect.

## Interface
- XLEN, 64: datapath width; legal values 32 or 64. If 32, `op[1]` (word) is ignored.
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  divider can accept; high only in IDLE
- op  in  3  `[0]` signed, `[1]` word (32-bit op, sign-extended result), `[2]` remainder (else quotient)
- op1  in  XLEN  dividend
- op2  in  XLEN  divisor
- out_valid  out  1  result valid; held until taken
- out_ready  in  1  consumer takes result
- out_result  out  XLEN  quotient or remainder
- flush  in  1  synchronous kill of any op in flight

## Operation
- Clock and reset: one clock `clk`. `rst` is asynchronous and active-high.
- Accept: an op is accepted on an edge where `in_valid & in_ready & ~flush`. On accept, `op`, `op1` and `op2` are registered; later input changes are ignored.
- Operand preparation on accept:
  - Word ops use `op1[31:0]` and `op2[31:0]`, with N = 32. Full ops use N = XLEN.
  - Signed ops take absolute values, record the quotient sign (sign1 ^ sign2) and the remainder sign (sign1).
- Special cases, detected on accept:
  - Divisor zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / -1 at width N): quotient = dividend; remainder = 0.
- States: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on accept (normal case); IDLE -> DONE on accept (special case).
  - CALC: restoring shift-subtract, one quotient bit per cycle, driven by a counter from N-1 down to 0; CALC -> FIX when the counter reaches 0.
  - FIX: negate the quotient or remainder per the recorded signs, select quotient or remainder, and sign-extend bit 31 to XLEN for word ops (including DIVUW/REMUW). FIX -> DONE.
  - DONE: `out_valid` = 1; DONE -> IDLE when `out_ready`.
- flush: from any state, the next state is IDLE and `out_valid` drops on that edge. When flush and `in_valid` are high in the same IDLE cycle, nothing is accepted. Flush in DONE with `out_ready` high discards the result; the consumer must ignore that handshake.
- `out_result` is stable the whole time `out_valid` is high.

## Timing
- Reset values: state IDLE, `out_valid` 0, `out_result` 0, counter 0, and all internal registers 0. `in_ready` is 1 immediately after reset.
- Normal latency: `out_valid` rises N+2 edges after the accept edge (N CALC cycles, then FIX, then DONE). That is 66 edges for 64-bit ops and 34 for word ops.
- Special-case latency: `out_valid` rises 1 edge after the accept edge.
- Back-pressure: DONE holds indefinitely while `out_ready` = 0.
- Throughput: no back-to-back accept. `in_ready` returns the edge after the result handshake.
- Reset asserted mid-op forces IDLE asynchronously; no result is produced.

## Structure
- Package `div_pkg`:
  - op bit positions `DIV_SIGNED`, `DIV_WORD`, `DIV_REM`;
  - state enum `div_state_t` {IDLE, CALC, FIX, DONE};
  - counter width localparam `$clog2(XLEN)`.
- Sub-module `div_prep`, combinational: word truncation, absolute value, sign capture and special-case flags. Instantiated once and registered by `div_iter` on accept.
- `div_iter` holds the FSM, the counter, the remainder/quotient shift register (2*XLEN wide), the fix-up logic and the output register.

## Test plan
- DIV signed, op1 = -7, op2 = 2, XLEN = 64 -> result -3 (0xFFFF_FFFF_FFFF_FFFD) exactly 66 edges after accept. REM on the same operands -> -1.
- DIVU, op1 = 0xFFFF_FFFF_FFFF_FFFF, op2 = 0 -> result 0xFFFF_FFFF_FFFF_FFFF, 1 edge after accept. REMU on the same operands -> op1.
- DIV, op1 = 0x8000_0000_0000_0000, op2 = -1 -> result 0x8000_0000_0000_0000, 1 edge after accept. REM on the same operands -> 0.
- DIVUW, op1 = 0x1_FFFF_FFFE, op2 = 1 -> 0xFFFF_FFFF_FFFF_FFFE after 34 edges. DIVW, op1[31:0] = 0x8000_0000, op2 = -1 -> 0xFFFF_FFFF_8000_0000 after 1 edge.
- Hold `out_ready` = 0 for 10 cycles in DONE -> `out_valid` and `out_result` stay stable, `in_ready` stays 0, and IDLE is reached on the edge after `out_ready` = 1.
- Flush at CALC cycle 20, with a new op presented on the next cycle -> no `out_valid` for the killed op. Assert `rst` mid-CALC -> `out_valid` = 0 and state IDLE immediately, without waiting for a clock edge.
